// File: rtl/lm07_read_scheduler_if.sv
// Signal bundle between the LM07 read scheduler and its users: requests, shared SPI pins, read results.
// Latency: none, this is a plain signal container.
// Backpressure: none; requests merge in the scheduler and results are single-cycle pulses.
interface lm07_read_scheduler_if #(
    parameter int NUM_SENS  = 4,
    parameter int READ_BITS = 16
);
    logic [NUM_SENS-1:0]  req;
    logic                 scan_en;
    logic                 SIO;
    logic [NUM_SENS-1:0]  CS_N;
    logic                 SCK;
    logic [NUM_SENS-1:0]  gnt;
    logic                 busy;
    logic [READ_BITS-1:0] rd_data;
    logic [1:0]           rd_id;
    logic                 rd_valid;

    // Requester / sensor-pin side
    modport master (
        output req, scan_en, SIO,
        input  CS_N, SCK, gnt, busy, rd_data, rd_id, rd_valid
    );

    // Scheduler side
    modport slave (
        input  req, scan_en, SIO,
        output CS_N, SCK, gnt, busy, rd_data, rd_id, rd_valid
    );
endinterface

// File: rtl/lm07_read_scheduler.sv
// Round-robin scheduler sharing one SPI bus among up to four LM07 sensors, one 16-bit read at a time.
// Latency: rd_valid high the cycle after edge 2+CS_SETUP+2*SCK_DIV*READ_BITS+CS_HOLD from the request edge.
// Backpressure: none; requests and scan ticks while busy only set pending bits, duplicates merge.
module lm07_read_scheduler #(
    parameter int NUM_SENS    = 4,
    parameter int SCK_DIV     = 2,
    parameter int READ_BITS   = 16,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int SCAN_PERIOD = 1000
) (
    input logic                 SYSCLK,
    input logic                 RSTN,
    lm07_read_scheduler_if.slave bus
);

    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(SCK_DIV + 1);
    localparam int BIT_W   = $clog2(READ_BITS + 1);
    localparam int SCAN_W  = $clog2(SCAN_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_SENS-1:0]   r_pending;
    logic [SCAN_W-1:0]     r_scan_cnt;
    logic [1:0]            r_last_id;
    logic [1:0]            r_id;
    logic [NUM_SENS-1:0]   r_gnt;
    logic [NUM_SENS-1:0]   r_cs_n;
    logic                  r_sck;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIV_W-1:0]      r_div;
    logic [BIT_W-1:0]      r_bit;
    logic [READ_BITS-1:0]  r_shift;
    logic [READ_BITS-1:0]  r_rd_data;
    logic [1:0]            r_rd_id;
    logic                  r_rd_valid;

    logic                  w_scan_tick;
    logic                  w_arb_found;
    logic [2:0]            w_arb_sum;
    logic [1:0]            w_arb_id;
    logic [NUM_SENS-1:0]   w_arb_oh;
    logic [NUM_SENS-1:0]   w_pend_set;
    logic [NUM_SENS-1:0]   w_pend_clr;
    logic                  w_half_end;
    logic                  w_fall;
    logic                  w_last_bit;
    logic                  w_setup_done;
    logic                  w_hold_done;

    assign w_scan_tick  = (r_scan_cnt == SCAN_W'(SCAN_PERIOD - 1));
    assign w_half_end   = (r_div == DIV_W'(SCK_DIV - 1));
    assign w_fall       = (r_state == S_SHIFT) && w_half_end && r_sck;
    assign w_last_bit   = (r_bit == BIT_W'(READ_BITS - 1));
    assign w_setup_done = (r_state == S_SETUP) && (r_cnt == CNT_W'(CS_SETUP - 1));
    assign w_hold_done  = (r_state == S_HOLD) && (r_cnt == CNT_W'(CS_HOLD - 1));

    // Pick the first pending sensor after the last one served, wrapping at NUM_SENS
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_id    = r_last_id;
        w_arb_sum   = '0;
        for (int k = 1; k <= NUM_SENS; k++) begin
            w_arb_sum = {1'b0, r_last_id} + 3'(k);
            if (w_arb_sum >= 3'(NUM_SENS)) begin
                w_arb_sum = w_arb_sum - 3'(NUM_SENS);
            end
            if (!w_arb_found && r_pending[w_arb_sum[1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_id    = w_arb_sum[1:0];
            end
        end
    end

    // Grant one-hot plus pending set/clear terms; a set in the clearing cycle wins
    always_comb begin
        w_arb_oh           = '0;
        w_arb_oh[w_arb_id] = 1'b1;
        w_pend_clr         = (r_state == S_ARB) ? w_arb_oh : '0;
        w_pend_set         = bus.req | ((w_scan_tick && bus.scan_en) ? '1 : '0);
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|r_pending) w_state_nxt = S_ARB;
            S_ARB:   w_state_nxt = S_SETUP;
            S_SETUP: if (w_setup_done) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_fall && w_last_bit) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_hold_done) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = (|r_pending) ? S_ARB : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pending bits and free-running scan counter
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pending  <= '0;
            r_scan_cnt <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_pend_clr) | w_pend_set;
            r_scan_cnt <= w_scan_tick ? '0 : r_scan_cnt + SCAN_W'(1);
        end
    end

    // Grant, round-robin pointer and chip-selects: CS falls at ARB exit, rises at SHIFT exit
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_id      <= '0;
            r_last_id <= 2'(NUM_SENS - 1);
            r_gnt     <= '0;
            r_cs_n    <= '1;
        end else begin
            if (r_state == S_ARB) begin
                r_id      <= w_arb_id;
                r_last_id <= w_arb_id;
                r_gnt     <= w_arb_oh;
                r_cs_n    <= ~w_arb_oh;
            end
            if (r_state == S_SHIFT && w_state_nxt == S_HOLD) begin
                r_cs_n <= '1;
            end
            if (r_state == S_DONE) begin
                r_gnt <= '0;
            end
        end
    end

    // Setup/hold dwell counter, restarted on every state change
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_SETUP || r_state == S_HOLD) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // SCK generator and shifter; SIO is captured on each SCK high-to-low edge
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_div   <= '0;
            r_sck   <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (r_state == S_SHIFT) begin
            if (w_half_end) begin
                r_div <= '0;
                r_sck <= ~r_sck;
                if (r_sck) begin
                    r_shift <= {r_shift[READ_BITS-2:0], bus.SIO};
                    r_bit   <= r_bit + BIT_W'(1);
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end else begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_bit <= '0;
        end
    end

    // Result registers, loaded on entry to DONE and held until the next read
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_id    <= '0;
        end else begin
            r_rd_valid <= w_hold_done;
            if (w_hold_done) begin
                r_rd_data <= r_shift;
                r_rd_id   <= r_id;
            end
        end
    end

    assign bus.CS_N     = r_cs_n;
    assign bus.SCK      = r_sck;
    assign bus.gnt      = r_gnt;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_id    = r_rd_id;
    assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_lm07_read_scheduler.sv
// Directed bench for lm07_read_scheduler with a four-sensor SPI slave model.
// Latency: expected rd_valid edges are hand-computed from the request edge.
// Backpressure: none; stimulus is request pulses and scan enable only.
module tb_lm07_read_scheduler;

    logic SYSCLK = 1'b0;
    logic RSTN   = 1'b0;

    lm07_read_scheduler_if #(.NUM_SENS(4), .READ_BITS(16)) bus ();

    lm07_read_scheduler #(
        .NUM_SENS    (4),
        .SCK_DIV     (2),
        .READ_BITS   (16),
        .CS_SETUP    (2),
        .CS_HOLD     (2),
        .SCAN_PERIOD (400)
    ) dut (
        .SYSCLK (SYSCLK),
        .RSTN   (RSTN),
        .bus    (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    int total = 0;
    int bad   = 0;

    // Sensor model and bus monitor state
    logic [15:0] sens_word [4];
    int          cs_low_cnt [4];
    int          sck_rise_cnt = 0;
    int          two_low_cnt  = 0;
    logic        m_prev_sck   = 1'b0;
    logic        m_active     = 1'b0;
    logic [15:0] m_sreg       = '0;
    int          m_nlow;
    int          m_sel;

    // Captured rd_valid events
    int          edge_no = 0;
    int          ev_edge [$];
    logic [1:0]  ev_id   [$];
    logic [15:0] ev_dat  [$];

    // Sensor model: present MSB when selected, advance after each SCK fall; also count bus activity
    always begin
        @(posedge SYSCLK);
        #1;
        m_nlow = 0;
        m_sel  = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.CS_N[i] === 1'b0) begin
                cs_low_cnt[i]++;
                m_nlow++;
                m_sel = i;
            end
        end
        if (m_nlow > 1) two_low_cnt++;
        if (!m_prev_sck && bus.SCK === 1'b1) sck_rise_cnt++;
        if (m_nlow == 0) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_sreg   = sens_word[m_sel];
        end else if (m_prev_sck && bus.SCK === 1'b0) begin
            m_sreg = {m_sreg[14:0], 1'b0};
        end
        m_prev_sck = (bus.SCK === 1'b1);
        bus.SIO    = m_sreg[15];
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic step();
        tick();
        edge_no++;
        if (bus.rd_valid === 1'b1) begin
            ev_edge.push_back(edge_no);
            ev_id.push_back(bus.rd_id);
            ev_dat.push_back(bus.rd_data);
        end
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_ev();
        ev_edge.delete();
        ev_id.delete();
        ev_dat.delete();
        edge_no = 0;
    endtask

    task automatic do_reset();
        RSTN    = 1'b0;
        bus.req = '0;
        repeat (3) tick();
        RSTN = 1'b1;
        clear_ev();
    endtask

    task automatic test_reset();
        RSTN        = 1'b0;
        bus.req     = '0;
        bus.scan_en = 1'b0;
        repeat (3) tick();
        total++; if (bus.CS_N !== 4'hF) begin bad++; $display("FAIL reset_cs_n got=%h exp=f", bus.CS_N); end
        total++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", bus.SCK); end
        total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
        total++; if (bus.rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        total++; if (bus.rd_id !== 2'd0) begin bad++; $display("FAIL reset_rd_id got=%0d exp=0", bus.rd_id); end
    endtask

    task automatic test_single_read();
        int s_cs [4];
        int s_rise;
        int gnt_bad;
        int exp_low;
        sens_word[2] = 16'h0C80;
        do_reset();
        for (int i = 0; i < 4; i++) s_cs[i] = cs_low_cnt[i];
        s_rise  = sck_rise_cnt;
        gnt_bad = 0;
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        for (int n = 1; n <= 71; n++) begin
            step();
            if (n >= 2 && n <= 70 && bus.gnt !== 4'b0100) gnt_bad++;
        end
        total++; if (gnt_bad != 0) begin bad++; $display("FAIL single_gnt bad_cycles=%0d exp=0", gnt_bad); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after_done got=%b exp=0", bus.busy); end
        total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL single_gnt_after_done got=%h exp=0", bus.gnt); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL single_valid_width got=%b exp=0", bus.rd_valid); end
        run_edges(10);
        for (int i = 0; i < 4; i++) begin
            exp_low = (i == 2) ? 66 : 0;
            total++; if (cs_low_cnt[i] - s_cs[i] != exp_low) begin bad++; $display("FAIL single_cs_low[%0d] got=%0d exp=%0d", i, cs_low_cnt[i] - s_cs[i], exp_low); end
        end
        total++; if (sck_rise_cnt - s_rise != 16) begin bad++; $display("FAIL single_sck_rises got=%0d exp=16", sck_rise_cnt - s_rise); end
        total++;
        if (ev_edge.size() != 1) begin
            bad++; $display("FAIL single_event_count got=%0d exp=1", ev_edge.size());
        end else begin
            total++; if (ev_edge[0] != 70) begin bad++; $display("FAIL single_latency got=%0d exp=70", ev_edge[0]); end
            total++; if (ev_dat[0] !== 16'h0C80) begin bad++; $display("FAIL single_rd_data got=%h exp=0c80", ev_dat[0]); end
            total++; if (ev_id[0] !== 2'd2) begin bad++; $display("FAIL single_rd_id got=%0d exp=2", ev_id[0]); end
        end
        total++; if (bus.rd_data !== 16'h0C80) begin bad++; $display("FAIL single_rd_data_hold got=%h exp=0c80", bus.rd_data); end
    endtask

    task automatic test_round_robin();
        int          s_two;
        int          s_cs2;
        int          exp_e [3];
        logic [1:0]  exp_i [3];
        logic [15:0] exp_d [3];
        exp_e = '{70, 140, 210};
        exp_i = '{2'd0, 2'd1, 2'd3};
        exp_d = '{16'h1111, 16'h2222, 16'h4444};
        sens_word[0] = 16'h1111;
        sens_word[1] = 16'h2222;
        sens_word[2] = 16'h3333;
        sens_word[3] = 16'h4444;
        do_reset();
        s_two   = two_low_cnt;
        s_cs2   = cs_low_cnt[2];
        bus.req = 4'b1011;
        tick();
        bus.req = '0;
        run_edges(230);
        total++;
        if (ev_edge.size() != 3) begin
            bad++; $display("FAIL rr_event_count got=%0d exp=3", ev_edge.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (ev_edge[k] != exp_e[k]) begin bad++; $display("FAIL rr_edge[%0d] got=%0d exp=%0d", k, ev_edge[k], exp_e[k]); end
                total++; if (ev_id[k] !== exp_i[k]) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, ev_id[k], exp_i[k]); end
                total++; if (ev_dat[k] !== exp_d[k]) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, ev_dat[k], exp_d[k]); end
            end
        end
        total++; if (two_low_cnt != s_two) begin bad++; $display("FAIL rr_two_cs_low cycles=%0d exp=0", two_low_cnt - s_two); end
        total++; if (cs_low_cnt[2] != s_cs2) begin bad++; $display("FAIL rr_unrequested_cs2 cycles=%0d exp=0", cs_low_cnt[2] - s_cs2); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_busy_end got=%b exp=0", bus.busy); end
    endtask

    task automatic test_merge_set_wins();
        int          exp_e [3];
        logic [1:0]  exp_i [3];
        exp_e = '{70, 140, 210};
        exp_i = '{2'd0, 2'd1, 2'd0};
        sens_word[0] = 16'hA5C3;
        sens_word[1] = 16'h5A3C;
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        step();                 // edge 1: enter ARB
        bus.req = 4'b0001;      // sampled on the ARB exit edge
        step();                 // edge 2
        bus.req = '0;
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL merge_first_gnt got=%h exp=1", bus.gnt); end
        for (int n = 3; n <= 300; n++) begin
            bus.req = (n == 10 || n == 20 || n == 30) ? 4'b0010 : 4'b0000;
            step();
        end
        bus.req = '0;
        total++;
        if (ev_edge.size() != 3) begin
            bad++; $display("FAIL merge_event_count got=%0d exp=3", ev_edge.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (ev_edge[k] != exp_e[k]) begin bad++; $display("FAIL merge_edge[%0d] got=%0d exp=%0d", k, ev_edge[k], exp_e[k]); end
                total++; if (ev_id[k] !== exp_i[k]) begin bad++; $display("FAIL merge_id[%0d] got=%0d exp=%0d", k, ev_id[k], exp_i[k]); end
            end
            total++; if (ev_dat[1] !== 16'h5A3C) begin bad++; $display("FAIL merge_data1 got=%h exp=5a3c", ev_dat[1]); end
        end
    endtask

    task automatic test_auto_scan();
        int          exp_e [8];
        logic [1:0]  exp_i [8];
        exp_e = '{470, 540, 610, 680, 870, 940, 1010, 1080};
        exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        sens_word[0] = 16'h1111;
        sens_word[1] = 16'h2222;
        sens_word[2] = 16'h3333;
        sens_word[3] = 16'h4444;
        bus.scan_en = 1'b1;
        do_reset();
        run_edges(399);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL scan_idle_before_tick got=%b exp=0", bus.busy); end
        run_edges(601);         // up to edge 1000, mid third read of round two
        bus.scan_en = 1'b0;
        run_edges(700);
        total++;
        if (ev_edge.size() != 8) begin
            bad++; $display("FAIL scan_event_count got=%0d exp=8", ev_edge.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++; if (ev_edge[k] != exp_e[k]) begin bad++; $display("FAIL scan_edge[%0d] got=%0d exp=%0d", k, ev_edge[k], exp_e[k]); end
                total++; if (ev_id[k] !== exp_i[k]) begin bad++; $display("FAIL scan_id[%0d] got=%0d exp=%0d", k, ev_id[k], exp_i[k]); end
            end
            total++; if (ev_dat[6] !== 16'h3333) begin bad++; $display("FAIL scan_data6 got=%h exp=3333", ev_dat[6]); end
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL scan_busy_end got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_shift();
        sens_word[0] = 16'h5A5A;
        sens_word[2] = 16'h0C80;
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        run_edges(9);
        bus.req = 4'b0010;
        step();                 // edge 10: sensor 1 becomes pending
        bus.req = '0;
        run_edges(23);          // edge 33, inside bit 7 of the shift
        total++; if (bus.CS_N !== 4'b1011) begin bad++; $display("FAIL rst_pre_cs_n got=%h exp=b", bus.CS_N); end
        #3;
        RSTN = 1'b0;
        #2;
        total++; if (bus.CS_N !== 4'hF) begin bad++; $display("FAIL rst_async_cs_n got=%h exp=f", bus.CS_N); end
        total++; if (bus.SCK !== 1'b0) begin bad++; $display("FAIL rst_async_sck got=%b exp=0", bus.SCK); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_async_rd_valid got=%b exp=0", bus.rd_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", bus.busy); end
        total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL rst_async_gnt got=%h exp=0", bus.gnt); end
        total++; if (dut.r_pending !== 4'h0) begin bad++; $display("FAIL rst_async_pending got=%h exp=0", dut.r_pending); end
        tick();
        RSTN = 1'b1;
        clear_ev();
        run_edges(200);
        total++; if (ev_edge.size() != 0) begin bad++; $display("FAIL rst_spurious_reads got=%0d exp=0", ev_edge.size()); end
        bus.req = 4'b1001;
        tick();
        bus.req = '0;
        clear_ev();
        run_edges(2);
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL rst_next_gnt got=%h exp=1", bus.gnt); end
        run_edges(68);
        total++;
        if (ev_edge.size() != 1) begin
            bad++; $display("FAIL rst_next_read_count got=%0d exp=1", ev_edge.size());
        end else begin
            total++; if (ev_id[0] !== 2'd0) begin bad++; $display("FAIL rst_next_id got=%0d exp=0", ev_id[0]); end
            total++; if (ev_dat[0] !== 16'h5A5A) begin bad++; $display("FAIL rst_next_data got=%h exp=5a5a", ev_dat[0]); end
        end
        run_edges(80);          // let the queued sensor-3 read drain
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sens_word[i]  = '0;
            cs_low_cnt[i] = 0;
        end
        bus.req     = '0;
        bus.scan_en = 1'b0;
        bus.SIO     = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_merge_set_wins();
        test_auto_scan();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lm07_read_scheduler.md
# lm07_read_scheduler

Round-robin read scheduler that shares one SPI bus (common SCK/SIO, per-device chip-selects) among up to four LM07 temperature sensors.
- It accepts on-demand read requests and an optional periodic auto-scan.
- It arbitrates among pending sensors and runs one 16-bit SPI read at a time.
- It returns the raw sensor word tagged with the sensor index.
- It sits between the sensor pins and the display/debug logic, and replaces free-running single-sensor polling.

## Interface
- NUM_SENS, 4: number of sensors and chip-selects, 1..4.
- SCK_DIV, 2: SYSCLK cycles per SCK half-period, ≥1.
- READ_BITS, 16: bits shifted per transaction.
- CS_SETUP, 2: cycles with CS_N low and SCK low before the first SCK rise, ≥1.
- CS_HOLD, 2: minimum cycles with CS_N high after a transaction, ≥1.
- SCAN_PERIOD, 1000: auto-scan tick interval in SYSCLK cycles, ≥2.

Ports:
- SYSCLK  in  1  system clock; all logic on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- req  in  NUM_SENS  one-cycle request pulses, one bit per sensor.
- scan_en  in  1  enables periodic auto-scan of all sensors.
- SIO  in  1  shared serial data from the sensors.
- CS_N  out  NUM_SENS  active-low chip-selects; at most one is low at a time.
- SCK  out  1  SPI clock, idle low.
- gnt  out  NUM_SENS  one-hot; identifies the sensor being served.
- busy  out  1  high whenever state ≠ IDLE.
- rd_data  out  READ_BITS  last word read, MSB first as received.
- rd_id  out  2  index of the sensor for rd_data.
- rd_valid  out  1  one-cycle pulse when rd_data/rd_id update.

## Operation
- pending[NUM_SENS-1:0]:
  - Sampling edge (the edge where req[i]=1 is registered): pending[i] sets.
  - Scan tick with scan_en=1: all pending bits set.
  - ARB cycle: the granted bit clears.
  - A set and a clear on the same bit in the same cycle: set wins, and the sensor is read again later.
  - Repeated requests while a bit is already pending merge into one read.
- Scan counter: counts 0..SCAN_PERIOD-1 and wraps. The tick is the cycle the counter reaches SCAN_PERIOD-1. The counter runs regardless of scan_en or busy.
- Round-robin pointer last_id, reset value NUM_SENS-1, so sensor 0 wins first. ARB grants the first pending index after last_id (modulo NUM_SENS), then updates last_id.
- States and transitions:
  - IDLE: goes to ARB if pending≠0.
  - ARB: one cycle; goes to SETUP and latches gnt/id.
  - SETUP: CS_SETUP cycles with CS_N[id]=0 and SCK=0; then goes to SHIFT.
  - SHIFT: lasts 2·SCK_DIV·READ_BITS cycles. SCK is low for SCK_DIV cycles, then high for SCK_DIV cycles, repeating. On each edge that drives SCK high→low, SIO is shifted into the LSB of the shift register (MSB first). The last sample coincides with SHIFT exit, leaving SCK=0.
  - HOLD: CS_N all high for CS_HOLD cycles; then goes to DONE.
  - DONE: one cycle. rd_data←shift register, rd_id←id, rd_valid=1. Goes to ARB if pending≠0, else IDLE.
- gnt[id] is high from ARB exit through the DONE cycle, and 0 otherwise.
- rd_data/rd_id hold their values between rd_valid pulses.
- req and scan ticks arriving while busy only update pending; they never abort a transaction.
- Reset, including mid-transaction, asynchronously forces:
  - CS_N all 1; SCK, gnt, busy, rd_valid, rd_data, rd_id all 0.
  - pending 0, scan counter 0, last_id NUM_SENS-1, state IDLE.

## Timing
- Latency with empty pending and IDLE state: rd_valid is high in the cycle after edge 2 + CS_SETUP + 2·SCK_DIV·READ_BITS + CS_HOLD, counted from the sampling edge. With defaults this is edge 70.
- CS_N[id] falls at ARB exit and rises at SHIFT exit.
- CS_N is low for CS_SETUP + 2·SCK_DIV·READ_BITS cycles (66 with defaults).
- Back-to-back reads: DONE goes directly to ARB, so transaction pitch is 1 + CS_SETUP + 2·SCK_DIV·READ_BITS + CS_HOLD + 1 cycles (70 with defaults). Minimum CS_N-high time between devices is CS_HOLD + 2.
- SCK duty cycle is exactly 50%; period is 2·SCK_DIV SYSCLK cycles; there are exactly READ_BITS rising edges per transaction.

## Test plan
- Single read, defaults, scan_en=0:
  - Stimulus: req[2] pulse; SIO model drives 0x0C80 on SCK falling edges.
  - Response: only CS_N[2] goes low, for 66 cycles; 16 SCK rises; rd_valid at edge 70 with rd_data=0x0C80, rd_id=2; gnt=4'b0100 throughout; busy drops after DONE.
- Round-robin order:
  - Stimulus: req=4'b1011 in one cycle; sensor models return 0x1111/0x2222/–/0x4444.
  - Response: service order 0, 1, 3; rd_valid pulses 70 cycles apart with matching rd_id/rd_data; CS_N never has two bits low.
- Merge and set-wins:
  - Stimulus: req[1] pulsed three times during one transaction on sensor 0, plus a req[0] pulse in the ARB cycle that grants sensor 0.
  - Response: exactly one more read of sensor 1 and one more read of sensor 0, in the order 1 then 0.
- Auto-scan:
  - Stimulus: SCAN_PERIOD=400, scan_en=1, no req.
  - Response: first tick sets all pending bits; reads 0, 1, 2, 3 back-to-back; the cycle repeats on each tick. Clearing scan_en stops new reads but lets the current transaction finish.
- Reset mid-SHIFT:
  - Stimulus: RSTN low asynchronously during bit 7.
  - Response: CS_N=4'hF, SCK=0, rd_valid=0, pending=0 immediately. After release, no rd_valid occurs without a new req, and the next grant goes to sensor 0.
